// File: rtl/pswd_auth_gen_if.sv
// pswd_auth_gen_if: user-entry, ROM and status bundle.
// The master side drives entry inputs and ROM data; the slave side is the controller.
interface pswd_auth_gen_if #(
    parameter int DIGIT_W  = 4,
    parameter int N_DIGITS = 4,
    parameter int ID_W     = 4,
    parameter int MAX_FAIL = 3
);
    localparam int PW = DIGIT_W * N_DIGITS;
    localparam int FW = $clog2(MAX_FAIL + 1);

    logic [DIGIT_W-1:0] in_toggle;
    logic               push_button;
    logic [ID_W-1:0]    internalid;
    logic               access_rom;
    logic               logout;
    logic [ID_W-1:0]    rom_addr;
    logic [PW-1:0]      rom_data;
    logic               redled;
    logic               greenled;
    logic               authorise_bit;
    logic               locked;
    logic [FW-1:0]      fail_count;

    modport master (
        output in_toggle, push_button, internalid,
        output access_rom, logout, rom_data,
        input  rom_addr, redled, greenled,
        input  authorise_bit, locked, fail_count
    );

    modport slave (
        input  in_toggle, push_button, internalid,
        input  access_rom, logout, rom_data,
        output rom_addr, redled, greenled,
        output authorise_bit, locked, fail_count
    );
endinterface

// File: rtl/pswd_auth_gen.sv
// pswd_auth_gen: digit entry, ROM fetch and compare, grant/deny.
// Consecutive mismatches are counted and trigger a timed lockout.
module pswd_auth_gen #(
    parameter int DIGIT_W     = 4,
    parameter int N_DIGITS    = 4,
    parameter int ID_W        = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    pswd_auth_gen_if.slave bus
);
    localparam int PW = DIGIT_W * N_DIGITS;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_FULL  = CW'(N_DIGITS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        FETCH,
        WAIT,
        COMPARE,
        GRANTED,
        DENIED,
        LOCKED
    } state_t;

    state_t          state;
    logic [PW-1:0]   entry;
    logic [CW-1:0]   dcnt;
    logic [ID_W-1:0] id_lat;
    logic [ID_W-1:0] rom_addr_q;
    logic [LW-1:0]   lock_cnt;
    logic            redled_q;
    logic            greenled_q;
    logic            auth_q;
    logic            locked_q;
    logic [FW-1:0]   fail_q;

    logic [PW-1:0] digit_ext;
    assign digit_ext = PW'(bus.in_toggle);

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            entry      <= '0;
            dcnt       <= '0;
            id_lat     <= '0;
            rom_addr_q <= '0;
            lock_cnt   <= '0;
            redled_q   <= 1'b0;
            greenled_q <= 1'b0;
            auth_q     <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= '0;
        end else if (bus.logout && state != LOCKED && state != IDLE) begin
            // Session end wins over everything but lockout; fail count survives.
            state      <= IDLE;
            entry      <= '0;
            dcnt       <= '0;
            redled_q   <= 1'b0;
            greenled_q <= 1'b0;
            auth_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.push_button) begin
                        entry <= digit_ext;
                        dcnt  <= CNT_ONE;
                        state <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (bus.access_rom && dcnt == CNT_FULL) begin
                        id_lat <= bus.internalid;
                        state  <= FETCH;
                    end else if (bus.push_button && dcnt != CNT_FULL) begin
                        entry <= (entry << DIGIT_W) | digit_ext;
                        dcnt  <= dcnt + CNT_ONE;
                    end
                end
                FETCH: begin
                    rom_addr_q <= id_lat;
                    state      <= WAIT;
                end
                WAIT: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    if (bus.rom_data == entry) begin
                        greenled_q <= 1'b1;
                        auth_q     <= 1'b1;
                        fail_q     <= '0;
                        state      <= GRANTED;
                    end else if (fail_q == FAIL_LAST) begin
                        redled_q <= 1'b1;
                        locked_q <= 1'b1;
                        fail_q   <= FAIL_MAX;
                        lock_cnt <= LOCK_LOAD;
                        state    <= LOCKED;
                    end else begin
                        redled_q <= 1'b1;
                        fail_q   <= fail_q + FW'(1);
                        state    <= DENIED;
                    end
                end
                GRANTED: begin
                    state <= GRANTED;
                end
                DENIED: begin
                    if (bus.push_button) begin
                        entry    <= digit_ext;
                        dcnt     <= CNT_ONE;
                        redled_q <= 1'b0;
                        state    <= ENTRY;
                    end
                end
                LOCKED: begin
                    if (lock_cnt == '0) begin
                        state    <= IDLE;
                        entry    <= '0;
                        dcnt     <= '0;
                        fail_q   <= '0;
                        redled_q <= 1'b0;
                        locked_q <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt - LW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.rom_addr      = rom_addr_q;
    assign bus.redled        = redled_q;
    assign bus.greenled      = greenled_q;
    assign bus.authorise_bit = auth_q;
    assign bus.locked        = locked_q;
    assign bus.fail_count    = fail_q;
endmodule

// File: tb/tb_pswd_auth_gen.sv
// tb_pswd_auth_gen: directed vectors plus hand-written corner sequences.
// ROM is modelled as a synchronous array inside the bench.
module tb_pswd_auth_gen;
    localparam int LC = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pswd_auth_gen_if #(
        .DIGIT_W(4), .N_DIGITS(4), .ID_W(4), .MAX_FAIL(3)
    ) bus ();

    pswd_auth_gen #(
        .DIGIT_W(4), .N_DIGITS(4), .ID_W(4),
        .MAX_FAIL(3), .LOCK_CYCLES(LC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [15:0] rom [16];

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    typedef struct {
        logic [3:0]  id;
        logic [15:0] pw;
        logic        g;
        logic        r;
        logic        l;
        logic [1:0]  fc;
        logic        cfc;
    } vec_t;

    vec_t vt[6];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] d);
        @(negedge clk);
        bus.in_toggle   = d;
        bus.push_button = 1'b1;
        @(negedge clk);
        bus.push_button = 1'b0;
    endtask

    task automatic push_all(input logic [15:0] pw);
        for (int k = 0; k < 4; k++) push(pw[15-4*k -: 4]);
    endtask

    task automatic verify(input string tag, input logic [3:0] id,
                          input logic g, input logic r, input logic l,
                          input logic [1:0] fc, input logic cfc,
                          input logic with_push);
        @(negedge clk);
        bus.internalid  = id;
        bus.access_rom  = 1'b1;
        bus.push_button = with_push;
        bus.in_toggle   = 4'hF;
        @(negedge clk);
        bus.access_rom  = 1'b0;
        bus.push_button = 1'b0;
        @(negedge clk);
        chk($sformatf("%s.addr", tag), 32'(bus.rom_addr), 32'(id));
        @(negedge clk);
        chk($sformatf("%s.lat", tag),
            32'({bus.greenled, bus.redled, bus.authorise_bit}), 32'(0));
        @(negedge clk);
        chk($sformatf("%s.green", tag), 32'(bus.greenled), 32'(g));
        chk($sformatf("%s.auth", tag), 32'(bus.authorise_bit), 32'(g));
        chk($sformatf("%s.red", tag), 32'(bus.redled), 32'(r));
        chk($sformatf("%s.lock", tag), 32'(bus.locked), 32'(l));
        if (cfc) chk($sformatf("%s.fc", tag), 32'(bus.fail_count), 32'(fc));
    endtask

    task automatic do_logout(input string tag);
        @(negedge clk);
        bus.logout = 1'b1;
        @(negedge clk);
        bus.logout = 1'b0;
        chk($sformatf("%s.lo", tag),
            32'({bus.greenled, bus.redled, bus.authorise_bit}), 32'(0));
    endtask

    task automatic idle_wait(input string tag, input logic [3:0] addr);
        repeat (4) @(negedge clk);
        chk($sformatf("%s.addr", tag), 32'(bus.rom_addr), 32'(addr));
        chk($sformatf("%s.leds", tag),
            32'({bus.greenled, bus.redled}), 32'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk($sformatf("%s.outs", tag),
            32'({bus.greenled, bus.redled, bus.authorise_bit, bus.locked}),
            32'(0));
        chk($sformatf("%s.fc", tag), 32'(bus.fail_count), 32'(0));
        chk($sformatf("%s.addr", tag), 32'(bus.rom_addr), 32'(0));
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        rom[5] = 16'h1A2B;
        rom[3] = 16'h0000;
        rom[7] = 16'h9C4E;

        vt[0] = '{4'd5, 16'h1A2B, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        vt[1] = '{4'd3, 16'h0001, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        vt[2] = '{4'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        vt[3] = '{4'd7, 16'h9C4E, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        vt[4] = '{4'd7, 16'h9C4F, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        vt[5] = '{4'd5, 16'h1A2B, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};

        bus.in_toggle   = '0;
        bus.push_button = 1'b0;
        bus.internalid  = '0;
        bus.access_rom  = 1'b0;
        bus.logout      = 1'b0;
        reset           = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            push_all(vt[i].pw);
            verify($sformatf("v%0d", i), vt[i].id, vt[i].g, vt[i].r,
                   vt[i].l, vt[i].fc, vt[i].cfc, 1'b0);
            if (vt[i].g) do_logout($sformatf("v%0d", i));
        end

        // Three digits only: access must not start a fetch.
        push(4'h1); push(4'hA); push(4'h2);
        @(negedge clk);
        bus.internalid = 4'd3;
        bus.access_rom = 1'b1;
        @(negedge clk);
        bus.access_rom = 1'b0;
        idle_wait("short", 4'd5);
        // Fourth digit fills; fifth is dropped.
        push(4'hB); push(4'hF);
        verify("fifth", 4'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        do_logout("fifth");

        // logout beats push in DENIED.
        push_all(16'h0000);
        verify("pd", 4'd5, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        bus.logout      = 1'b1;
        bus.push_button = 1'b1;
        bus.in_toggle   = 4'h1;
        @(negedge clk);
        bus.logout      = 1'b0;
        bus.push_button = 1'b0;
        chk("pri.red", 32'(bus.redled), 32'(0));
        chk("pri.fc", 32'(bus.fail_count), 32'(1));
        push(4'h1); push(4'hA); push(4'h2);
        @(negedge clk);
        bus.internalid = 4'd3;
        bus.access_rom = 1'b1;
        @(negedge clk);
        bus.access_rom = 1'b0;
        idle_wait("pri.cnt", 4'd5);
        push(4'hB);
        // access beats push with a full entry.
        verify("pa", 4'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        do_logout("pa");

        // Lockout length and input immunity.
        push_all(16'h0000);
        verify("lk1", 4'd5, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        push_all(16'h0000);
        verify("lk2", 4'd5, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        push_all(16'h0000);
        verify("lk3", 4'd5, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        cnt = 0;
        while (bus.locked && cnt < 40) begin
            cnt++;
            bus.in_toggle   = 4'h1;
            bus.internalid  = 4'd5;
            bus.push_button = (cnt == 1);
            bus.access_rom  = (cnt == 2);
            bus.logout      = (cnt == 3);
            @(negedge clk);
        end
        bus.push_button = 1'b0;
        bus.access_rom  = 1'b0;
        bus.logout      = 1'b0;
        chk("lk.len", 32'(cnt), 32'(LC));
        chk("lk.fc", 32'(bus.fail_count), 32'(0));
        chk("lk.leds", 32'({bus.greenled, bus.redled}), 32'(0));
        push_all(16'h1A2B);
        verify("after", 4'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        do_logout("after");

        // Reset while in WAIT.
        push_all(16'h1A2B);
        @(negedge clk);
        bus.internalid = 4'd5;
        bus.access_rom = 1'b1;
        @(negedge clk);
        bus.access_rom = 1'b0;
        @(negedge clk);
        chk("rw.pre", 32'(bus.rom_addr), 32'(5));
        reset = 1'b0;
        #1;
        chk_zero("rw");
        @(negedge clk);
        reset = 1'b1;

        // Reset while LOCKED.
        push_all(16'h0000);
        verify("rl1", 4'd5, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        push_all(16'h0000);
        verify("rl2", 4'd5, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        push_all(16'h0000);
        verify("rl3", 4'd5, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero("rl");
        @(negedge clk);
        reset = 1'b1;
        push_all(16'h1A2B);
        verify("post", 4'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        do_logout("post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
